// File: rtl/adder_response_checker.sv
// adder_response_checker
// Scores a stream of full-adder responses against the ideal full-adder
// truth table. A run is opened by a start pulse carrying the number of
// vectors to expect. Each valid cycle in RUN consumes one vector. The block
// counts vectors and mismatches and keeps the first failing vector. It then
// parks in DONE with a pass/fail verdict until the next start.
module adder_response_checker #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vectors,
    input  logic             valid,
    input  logic             x,
    input  logic             y,
    input  logic             c_in,
    input  logic             sum,
    input  logic             c_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_err_index,
    output logic [4:0]       first_err_vector
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Ideal full-adder sum bit.
    function automatic logic f_sum_exp(input logic a, input logic b, input logic ci);
        return a ^ b ^ ci;
    endfunction

    // Ideal full-adder carry-out (majority of the three inputs).
    function automatic logic f_cout_exp(input logic a, input logic b, input logic ci);
        return (a & b) | (a & ci) | (b & ci);
    endfunction

    // Case inequality so that an X or Z on the response in simulation scores
    // as a mismatch rather than silently comparing as unknown.
    function automatic logic f_mismatch(input logic s_act, input logic c_act,
                                        input logic s_exp, input logic c_exp);
        return (s_act !== s_exp) || (c_act !== c_exp);
    endfunction

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_target;
    logic [CNT_W-1:0] r_vec_count;
    logic [CNT_W-1:0] r_err_count;
    logic [CNT_W-1:0] r_first_idx;
    logic [4:0]       r_first_vec;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;

    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_target_nxt;
    logic [CNT_W-1:0] w_vec_count_nxt;
    logic [CNT_W-1:0] w_err_count_nxt;
    logic [CNT_W-1:0] w_first_idx_nxt;
    logic [4:0]       w_first_vec_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_pass_nxt;

    logic             w_sum_exp;
    logic             w_cout_exp;
    logic             w_mismatch;
    logic [CNT_W-1:0] w_vec_inc;

    assign w_sum_exp  = f_sum_exp(x, y, c_in);
    assign w_cout_exp = f_cout_exp(x, y, c_in);
    assign w_mismatch = f_mismatch(sum, c_out, w_sum_exp, w_cout_exp);
    assign w_vec_inc  = r_vec_count + CNT_W'(1);

    // Next-state and next-output computation for the IDLE/RUN/DONE controller.
    always_comb begin
        w_state_nxt     = r_state;
        w_target_nxt    = r_target;
        w_vec_count_nxt = r_vec_count;
        w_err_count_nxt = r_err_count;
        w_first_idx_nxt = r_first_idx;
        w_first_vec_nxt = r_first_vec;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                // A zero-length run completes immediately with a clean verdict.
                if (start) begin
                    w_vec_count_nxt = '0;
                    w_err_count_nxt = '0;
                    w_first_idx_nxt = '0;
                    w_first_vec_nxt = '0;
                    w_target_nxt    = num_vectors;
                    w_state_nxt     = (num_vectors != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                // start is deliberately ignored here; only valid advances the run.
                if (valid) begin
                    w_vec_count_nxt = w_vec_inc;
                    if (w_mismatch) begin
                        w_err_count_nxt = r_err_count + CNT_W'(1);
                        if (r_err_count == '0) begin
                            w_first_idx_nxt = r_vec_count;
                            w_first_vec_nxt = {x, y, c_in, sum, c_out};
                        end
                    end
                    if (w_vec_inc == r_target) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Status flags are derived from the state being entered so that they
        // are registered together with it and can never disagree.
        w_busy_nxt = (w_state_nxt == ST_RUN);
        w_done_nxt = (w_state_nxt == ST_DONE);
        w_pass_nxt = w_done_nxt && (w_err_count_nxt == '0);
    end

    // State, counters and status registers; reset abandons any run in progress.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_target    <= '0;
            r_vec_count <= '0;
            r_err_count <= '0;
            r_first_idx <= '0;
            r_first_vec <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_target    <= w_target_nxt;
            r_vec_count <= w_vec_count_nxt;
            r_err_count <= w_err_count_nxt;
            r_first_idx <= w_first_idx_nxt;
            r_first_vec <= w_first_vec_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_pass      <= w_pass_nxt;
        end
    end

    assign busy             = r_busy;
    assign done             = r_done;
    assign pass             = r_pass;
    assign vec_count        = r_vec_count;
    assign err_count        = r_err_count;
    assign first_err_index  = r_first_idx;
    assign first_err_vector = r_first_vec;

endmodule

// File: tb/tb_adder_response_checker.sv
// Directed bench for adder_response_checker: table-driven runs plus
// hand-written sequences for gaps, reset, zero-length runs and restarts.
module tb_adder_response_checker;

    localparam int CNT_W = 8;

    logic             clock;
    logic             reset;
    logic             start;
    logic [CNT_W-1:0] num_vectors;
    logic             valid;
    logic             x, y, c_in, sum, c_out;
    logic             busy, done, pass;
    logic [CNT_W-1:0] vec_count, err_count, first_err_index;
    logic [4:0]       first_err_vector;

    int total;
    int bad;

    typedef struct {
        logic x;
        logic y;
        logic ci;
        logic s;
        logic co;
        int   exp_vc;
        int   exp_ec;
    } vec_t;

    vec_t good8 [8];
    vec_t bad8  [8];

    adder_response_checker #(.CNT_W(CNT_W)) dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .num_vectors      (num_vectors),
        .valid            (valid),
        .x                (x),
        .y                (y),
        .c_in             (c_in),
        .sum              (sum),
        .c_out            (c_out),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .vec_count        (vec_count),
        .err_count        (err_count),
        .first_err_index  (first_err_index),
        .first_err_vector (first_err_vector)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_start(input int n);
        start       = 1'b1;
        num_vectors = CNT_W'(n);
        tick();
        start       = 1'b0;
        num_vectors = '0;
    endtask

    task automatic send(input logic a, input logic b, input logic ci,
                        input logic s, input logic co);
        valid = 1'b1;
        x = a; y = b; c_in = ci; sum = s; c_out = co;
        tick();
        valid = 1'b0;
        x = 1'b0; y = 1'b0; c_in = 1'b0; sum = 1'b0; c_out = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " busy"}, int'(busy), 0);
        check({tag, " done"}, int'(done), 0);
        check({tag, " pass"}, int'(pass), 0);
        check({tag, " vec_count"}, int'(vec_count), 0);
        check({tag, " err_count"}, int'(err_count), 0);
        check({tag, " first_idx"}, int'(first_err_index), 0);
        check({tag, " first_vec"}, int'(first_err_vector), 0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        start = 1'b0;
        num_vectors = '0;
        valid = 1'b0;
        x = 1'b0; y = 1'b0; c_in = 1'b0; sum = 1'b0; c_out = 1'b0;

        // Full-adder truth table, hand-computed: {x,y,ci} -> {s,co}.
        good8[0] = '{0,0,0, 0,0, 1,0};
        good8[1] = '{0,0,1, 1,0, 2,0};
        good8[2] = '{0,1,0, 1,0, 3,0};
        good8[3] = '{0,1,1, 0,1, 4,0};
        good8[4] = '{1,0,0, 1,0, 5,0};
        good8[5] = '{1,0,1, 0,1, 6,0};
        good8[6] = '{1,1,0, 0,1, 7,0};
        good8[7] = '{1,1,1, 1,1, 8,0};
        // Same run, but index 3 is a wrong response: 1+1+0 reported as s=1,co=1.
        bad8[0] = '{0,0,0, 0,0, 1,0};
        bad8[1] = '{0,0,1, 1,0, 2,0};
        bad8[2] = '{0,1,0, 1,0, 3,0};
        bad8[3] = '{1,1,0, 1,1, 4,1};
        bad8[4] = '{1,0,0, 1,0, 5,1};
        bad8[5] = '{1,0,1, 0,1, 6,1};
        bad8[6] = '{1,1,0, 0,1, 7,1};
        bad8[7] = '{1,1,1, 1,1, 8,1};

        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();
        check("idle busy", int'(busy), 0);

        // Clean run of all eight input combinations.
        do_start(8);
        check("run1 busy after start", int'(busy), 1);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) check("run1 not done before last", int'(done), 0);
            send(good8[i].x, good8[i].y, good8[i].ci, good8[i].s, good8[i].co);
            check($sformatf("run1 vc[%0d]", i), int'(vec_count), good8[i].exp_vc);
            check($sformatf("run1 ec[%0d]", i), int'(err_count), good8[i].exp_ec);
        end
        check("run1 done", int'(done), 1);
        check("run1 busy", int'(busy), 0);
        check("run1 pass", int'(pass), 1);

        // Run with one faulty response at index 3, restarted from DONE.
        do_start(8);
        check("run2 vc cleared", int'(vec_count), 0);
        for (int i = 0; i < 8; i++) begin
            send(bad8[i].x, bad8[i].y, bad8[i].ci, bad8[i].s, bad8[i].co);
            check($sformatf("run2 vc[%0d]", i), int'(vec_count), bad8[i].exp_vc);
            check($sformatf("run2 ec[%0d]", i), int'(err_count), bad8[i].exp_ec);
        end
        check("run2 done", int'(done), 1);
        check("run2 pass", int'(pass), 0);
        check("run2 first_idx", int'(first_err_index), 3);
        check("run2 first_vec", int'(first_err_vector), 5'b11011);

        // N=4 with valid only on alternate cycles; a start in a gap is ignored.
        do_start(4);
        for (int i = 0; i < 4; i++) begin
            send(good8[i].x, good8[i].y, good8[i].ci, good8[i].s, good8[i].co);
            check($sformatf("gap vc[%0d]", i), int'(vec_count), i + 1);
            if (i < 3) begin
                check($sformatf("gap busy[%0d]", i), int'(busy), 1);
                check($sformatf("gap done[%0d]", i), int'(done), 0);
                if (i == 1) begin
                    start = 1'b1;
                    num_vectors = 8'd1;
                end
                tick();
                start = 1'b0;
                num_vectors = '0;
                check($sformatf("gap hold vc[%0d]", i), int'(vec_count), i + 1);
            end
        end
        check("gap done", int'(done), 1);
        check("gap pass", int'(pass), 1);

        // Reset mid-run after three vectors, asserted away from the clock edge.
        do_start(8);
        for (int i = 0; i < 3; i++)
            send(good8[i].x, good8[i].y, good8[i].ci, good8[i].s, good8[i].co);
        check("pre-reset vc", int'(vec_count), 3);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("async reset");
        tick();
        reset = 1'b0;
        tick();
        check("post-reset idle busy", int'(busy), 0);
        send(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check("idle valid ignored vc", int'(vec_count), 0);
        check("idle valid ignored ec", int'(err_count), 0);
        do_start(2);
        send(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        send(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("post-reset run done", int'(done), 1);
        check("post-reset run pass", int'(pass), 1);
        check("post-reset run vc", int'(vec_count), 2);

        // Zero-length run from IDLE.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        do_start(0);
        check("zero done", int'(done), 1);
        check("zero pass", int'(pass), 1);
        check("zero busy", int'(busy), 0);
        check("zero vc", int'(vec_count), 0);

        // All sums inverted, then hold in DONE, then clean restart.
        do_start(4);
        for (int i = 0; i < 4; i++) begin
            send(good8[i].x, good8[i].y, good8[i].ci, ~good8[i].s, good8[i].co);
            check($sformatf("inv ec[%0d]", i), int'(err_count), i + 1);
        end
        check("inv done", int'(done), 1);
        check("inv pass", int'(pass), 0);
        check("inv first_idx", int'(first_err_index), 0);
        check("inv first_vec", int'(first_err_vector), 5'b00010);
        send(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        check("done hold ec", int'(err_count), 4);
        check("done hold done", int'(done), 1);
        do_start(2);
        check("restart busy", int'(busy), 1);
        check("restart ec cleared", int'(err_count), 0);
        send(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        send(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("restart done", int'(done), 1);
        check("restart ec", int'(err_count), 0);
        check("restart pass", int'(pass), 1);
        check("restart vc", int'(vec_count), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adder_response_checker.md
ADDER_RESPONSE_CHECKER -- requirements
Module: adder_response_checker

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of all vector counts and indices.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on posedge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  one-cycle pulse beginning a check run.
REQ-005 SHALL have port num_vectors  input  CNT_W  vectors to check in the run, sampled on an accepted start.
REQ-006 SHALL have port valid  input  1  the x, y, c_in, sum and c_out inputs hold a vector to check this cycle.
REQ-007 SHALL have ports x, y, c_in  input  1 each  full-adder stimulus bits.
REQ-008 SHALL have ports sum, c_out  input  1 each  full-adder response bits under check.
REQ-009 SHALL have port busy  output  1  high while in RUN.
REQ-010 SHALL have port done  output  1  high while in DONE.
REQ-011 SHALL have port pass  output  1  high in DONE when err_count is 0.
REQ-012 SHALL have port vec_count  output  CNT_W  vectors checked so far in the current run.
REQ-013 SHALL have port err_count  output  CNT_W  mismatching vectors in the current run.
REQ-014 SHALL have port first_err_index  output  CNT_W  vec_count value of the first mismatching vector.
REQ-015 SHALL have port first_err_vector  output  5  first mismatching vector, packed as {x,y,c_in,sum,c_out}.

Function
REQ-016 SHALL implement a three-state FSM: IDLE, RUN, DONE; all outputs registered.
REQ-017 IDLE: start=1 with num_vectors>0 SHALL go to RUN, latch num_vectors, and clear vec_count, err_count, first_err_index and first_err_vector.
REQ-018 IDLE or DONE: start=1 with num_vectors=0 SHALL go to DONE next cycle with counters cleared and pass=1.
REQ-019 Expected response SHALL be sum_exp = x^y^c_in and c_out_exp = (x&y)|(x&c_in)|(y&c_in).
REQ-020 RUN: each cycle with valid=1 SHALL be one accepted vector, and vec_count SHALL increment by 1.
REQ-021 On an accepted vector, any difference between sum/c_out and the expected values, including X or Z on sum/c_out, SHALL be a mismatch and SHALL increment err_count by 1.
REQ-022 On the first mismatch of a run, first_err_index SHALL be set to the pre-increment vec_count and first_err_vector SHALL be set to the inputs; later mismatches SHALL not alter either.
REQ-023 RUN: valid=0 cycles SHALL change no counter; gaps of any length are allowed.
REQ-024 RUN: the accepted vector making vec_count equal the latched count SHALL cause DONE on the next cycle; done rises 1 cycle after the last vector's valid cycle.
REQ-025 RUN: start SHALL be ignored; valid outside RUN SHALL be ignored.
REQ-026 DONE: outputs SHALL hold until start; start with num_vectors>0 SHALL restart as in REQ-017.
REQ-027 err_count SHALL never exceed vec_count; counters SHALL not wrap because vec_count is bounded by the latched count.
REQ-028 busy, done and pass SHALL be mutually consistent: busy and done are never both 1, and pass=1 only when done=1.

Reset
REQ-029 reset=1 SHALL immediately force IDLE and zero busy, done, pass, vec_count, err_count, first_err_index and first_err_vector.
REQ-030 Reset mid-RUN SHALL abandon the run; after deassertion the block SHALL wait in IDLE for start.

Verification
REQ-031 Scenario: start with num_vectors=8, then all 8 {x,y,c_in} combinations with correct sum/c_out on consecutive valid cycles -> done=1 one cycle after the 8th vector, pass=1, err_count=0, vec_count=8.
REQ-032 Scenario: N=8 with vector index 3 driven as x=1,y=1,c_in=0,sum=1,c_out=1 -> err_count=1, first_err_index=3, first_err_vector=5'b11011, pass=0.
REQ-033 Scenario: N=4 with valid asserted only on alternate cycles -> vec_count steps 1,2,3,4 only on valid cycles; done 1 cycle after the 4th vector.
REQ-034 Scenario: start with num_vectors=0 -> done=1 and pass=1 on the next cycle, busy never 1.
REQ-035 Scenario: reset pulsed after 3 of N=8 vectors -> all outputs 0 asynchronously; a new start with N=2 and 2 correct vectors -> pass=1, vec_count=2.
REQ-036 Scenario: N=4 with all sum inverted, then restart from DONE with N=2 and correct vectors -> first run err_count=4 and first_err_index=0; second run err_count=0 and pass=1.
